// File: rtl/rom_stream_loader_verify.sv
// rtl/rom_stream_loader_verify.sv - streams host words into memory with optional write-read-verify and retry
module rom_stream_loader_verify #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BASE_ADDRESS  = 0,
    parameter int MAX_WORDS     = 32768,
    parameter int RETRIES       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    input_data,
    input  logic                     finish,
    input  logic                     verify_en,
    output logic                     load_received,
    output logic                     ack,
    output logic                     mem_request,
    output logic                     mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    input  logic                     mem_busy,
    input  logic                     mem_initialized,
    output logic [ADDRESS_WIDTH-1:0] word_count,
    output logic                     done,
    output logic                     overflow,
    output logic                     verify_error,
    output logic [ADDRESS_WIDTH-1:0] error_address
);

    localparam int ATTEMPT_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    state_t               state, state_next;
    logic                 verify_q;
    logic [ATTEMPT_W-1:0] attempts;
    logic                 room;
    logic                 capture;
    logic                 overflow_hit;
    logic                 retry;
    logic                 fail;

    // Extra bit so MAX_WORDS == 2^ADDRESS_WIDTH still compares correctly
    assign room = {1'b0, word_count} < (ADDRESS_WIDTH + 1)'(MAX_WORDS);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        capture      = 1'b0;
        overflow_hit = 1'b0;
        retry        = 1'b0;
        fail         = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    if (!room) begin
                        overflow_hit = 1'b1;
                    end else if (mem_initialized) begin
                        capture    = 1'b1;
                        state_next = S_WR_REQ;
                    end
                end else if (finish) begin
                    state_next = S_DONE;
                end
            end
            S_WR_REQ:  if (mem_busy)  state_next = S_WR_WAIT;
            S_WR_WAIT: if (!mem_busy) state_next = verify_q ? S_RD_REQ : S_ACK;
            S_RD_REQ:  if (mem_busy)  state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (!mem_busy) begin
                    if (mem_read_data == mem_write_data) begin
                        state_next = S_ACK;
                    end else if (attempts < ATTEMPT_W'(RETRIES)) begin
                        retry      = 1'b1;
                        state_next = S_WR_REQ;
                    end else begin
                        fail       = 1'b1;
                        state_next = S_ACK;
                    end
                end
            end
            S_ACK:   state_next = S_IDLE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    assign mem_request      = (state == S_WR_REQ) || (state == S_RD_REQ);
    assign mem_write_enable = (state == S_WR_REQ);
    assign ack              = (state == S_ACK);
    assign done             = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            load_received  <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            verify_q       <= 1'b0;
            attempts       <= '0;
            word_count     <= '0;
            overflow       <= 1'b0;
            verify_error   <= 1'b0;
            error_address  <= '0;
        end else begin
            load_received <= capture;
            if (capture) begin
                mem_address    <= ADDRESS_WIDTH'(BASE_ADDRESS) + word_count;
                mem_write_data <= input_data;
                verify_q       <= verify_en;
            end
            if (overflow_hit) overflow <= 1'b1;
            if (retry)        attempts <= attempts + 1'b1;
            if (fail) begin
                verify_error <= 1'b1;
                if (!verify_error) error_address <= mem_address;
            end
            if (state == S_ACK) begin
                word_count <= word_count + 1'b1;
                attempts   <= '0;
            end
        end
    end

endmodule
